// File: rtl/serial_adder_fsm_if.sv
// Operand/result bundle for serial_adder_fsm.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_fsm_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
`else
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
`endif
endinterface

// File: rtl/serial_adder_fsm.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, one bit per clock, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_fsm #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_fsm_if.slave   bus_io
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] res_sr_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q;
`endif

  // Full-adder cell fed from the operand shift registers and the carry flop.
  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] res_sr_d;

  assign fa_s     = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign fa_c     = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
  assign res_sr_d = {fa_s, res_sr_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (bus_io.start) begin
            a_sr_q   <= bus_io.a;
            b_sr_q   <= bus_io.b;
            carry_q  <= bus_io.cin;
            res_sr_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= StShift;
          end else begin
            state_q  <= StIdle;
          end
        end
        StShift: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          carry_q  <= fa_c;
          res_sr_q <= res_sr_d;
          cnt_q    <= cnt_q + CntW'(1);
          // Last bit: capture the result on the same edge so it is valid with done.
          if (cnt_q == LastCnt) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= res_sr_d;
            cout_q  <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= carry_q ^ fa_c;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.busy = busy_q;
  assign bus_io.done = done_q;
  assign bus_io.sum  = sum_q;
  assign bus_io.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus_io.ovf  = ovf_q;
`endif

endmodule
